// File: rtl/uart_transmitter.sv
// UART 16750 transmit engine: drains the TX FIFO and serialises start/data/parity/stop on SOUT.
// Optional `define UART_TX_AUTOCTS_EN adds AFE/CTSN automatic flow control on character loads.
module uart_transmitter #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TXCLK,
    input  logic       TXSTART,
    input  logic [7:0] DIN,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
`ifdef UART_TX_AUTOCTS_EN
    input  logic       AFE,
    input  logic       CTSN,
`endif
    output logic       READ,
    output logic       TXFINISHED,
    output logic       SOUT
);

    localparam int CW = $clog2(OVERSAMPLE) + 1;
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] tick_cnt, tick_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shreg, shreg_n;
    logic [1:0]    sh_wls;
    logic          sh_stb;
    logic          sh_pen;
    logic          sh_par;
    logic          load;
    logic          load_ok;
    logic          bit_done;
    logic          last_bit;
    logic [CW-1:0] tick_last;
    logic [7:0]    data_mask;
    logic          par_calc;
    logic          sout_d;

`ifdef UART_TX_AUTOCTS_EN
    logic [1:0] cts_sync;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cts_sync <= '0;
        end else begin
            cts_sync <= {cts_sync[0], CTSN};
        end
    end

    always_comb load_ok = TXSTART & ~(AFE & cts_sync[1]);
`else
    always_comb load_ok = TXSTART;
`endif

    // Parity is resolved from the live inputs at load time so later register writes cannot alter it.
    always_comb begin
        case (WLS)
            2'b00:   data_mask = 8'h1F;
            2'b01:   data_mask = 8'h3F;
            2'b10:   data_mask = 8'h7F;
            default: data_mask = 8'hFF;
        endcase
        par_calc = SP ? ~EPS : ((^(DIN & data_mask)) ^ ~EPS);
    end

    always_comb begin
        tick_last = (state == STOP2 && sh_wls == 2'b00) ? HALF_LAST : FULL_LAST;
        bit_done  = TXCLK && (tick_cnt == tick_last);
        last_bit  = (bit_cnt == ({1'b0, sh_wls} + 3'd4));
    end

    always_comb begin
        state_n = state;
        tick_n  = TXCLK ? tick_cnt + CW'(1) : tick_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        load    = 1'b0;

        case (state)
            IDLE: begin
                if (load_ok) load = 1'b1;
            end
            START: begin
                if (bit_done) state_n = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    if (last_bit) begin
                        state_n = sh_pen ? PARITY : STOP1;
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_n = STOP1;
            end
            STOP1: begin
                if (bit_done) begin
                    if (sh_stb)       state_n = STOP2;
                    else if (load_ok) load    = 1'b1;
                    else              state_n = IDLE;
                end
            end
            STOP2: begin
                if (bit_done) begin
                    if (load_ok) load    = 1'b1;
                    else         state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (load) begin
            state_n = START;
            bit_n   = '0;
        end
        if (bit_done || state == IDLE) tick_n = '0;
    end

    // SOUT is computed from the next state so the registered output lines up with the state register.
    always_comb begin
        case (state_n)
            START:   sout_d = 1'b0;
            DATA:    sout_d = shreg_n[0];
            PARITY:  sout_d = sh_par;
            default: sout_d = 1'b1;
        endcase
    end

    always_comb READ = load & RST_N;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            sh_wls     <= '0;
            sh_stb     <= 1'b0;
            sh_pen     <= 1'b0;
            sh_par     <= 1'b0;
            SOUT       <= 1'b1;
            TXFINISHED <= 1'b1;
        end else begin
            state      <= state_n;
            tick_cnt   <= tick_n;
            bit_cnt    <= bit_n;
            SOUT       <= BC ? 1'b0 : sout_d;
            TXFINISHED <= (state_n == IDLE);
            if (load) begin
                shreg  <= DIN;
                sh_wls <= WLS;
                sh_stb <= STB;
                sh_pen <= PEN;
                sh_par <= par_calc;
            end else begin
                shreg  <= shreg_n;
            end
        end
    end

endmodule
